// File: rtl/vector_pingpong_mem.sv
// Double-buffered vector memory: one bank is read while the other is filled.
// Adds masked writes, bank swap, a clear sequencer and address checks.
module vector_pingpong_mem #(
  parameter int element_width = 64,
  parameter int no_of_units   = 8,
  parameter int address_width = 20,
  parameter int depth         = 1001
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   wr_en,
  input  logic [no_of_units-1:0]                 wr_lane_mask,
  input  logic [address_width-1:0]               wr_addr,
  input  logic [no_of_units*element_width-1:0]   wr_data,
  input  logic                                   rd_en,
  input  logic [address_width-1:0]               rd_addr,
  output logic [no_of_units*element_width-1:0]   rd_data,
  output logic                                   rd_valid,
  input  logic                                   swap,
  input  logic                                   clear_start,
  output logic                                   busy,
  output logic                                   finish,
  output logic                                   active_bank,
  output logic                                   addr_err
);

  localparam int dw = element_width * no_of_units;
  localparam int iw = (depth > 1) ? $clog2(depth) : 1;
  localparam logic [address_width-1:0] lim = address_width'(depth);
  localparam logic [iw-1:0] last = iw'(depth - 1);

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    DONE
  } state_t;

  state_t state, state_nx;
  logic [iw-1:0] cnt, cnt_nx;
  logic [dw-1:0] mem [2][depth];

  logic [iw-1:0] ra, wa;
  logic rd_bad, wr_go, wr_bad;
  logic unused_addr;

  assign ra = rd_addr[iw-1:0];
  assign wa = wr_addr[iw-1:0];
  assign unused_addr = ^{rd_addr[address_width-1:iw],
                         wr_addr[address_width-1:iw]};

  assign busy   = (state == CLEAR);
  assign finish = (state == DONE);

  assign rd_bad = (rd_addr >= lim);
  // all-zero mask is a pure no-op, so it can never raise an error
  assign wr_go  = wr_en && !busy && (|wr_lane_mask);
  assign wr_bad = wr_go && (wr_addr >= lim);

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    unique case (state)
      IDLE: begin
        if (clear_start) begin
          state_nx = CLEAR;
          cnt_nx   = '0;
        end
      end
      CLEAR: begin
        if (cnt == last) state_nx = DONE;
        else             cnt_nx   = cnt + 1'b1;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // storage is deliberately not reset; writes always land in the shadow bank
  always_ff @(posedge clk) begin
    if (busy) begin
      mem[~active_bank][cnt] <= '0;
    end else if (wr_go && !wr_bad) begin
      for (int i = 0; i < no_of_units; i++) begin
        if (wr_lane_mask[i])
          mem[~active_bank][wa][i*element_width +: element_width]
            <= wr_data[i*element_width +: element_width];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data     <= '0;
      rd_valid    <= 1'b0;
      active_bank <= 1'b0;
      addr_err    <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        if (rd_bad) rd_data <= '0;
        else        rd_data <= mem[active_bank][ra];
      end
      if (swap && !busy) active_bank <= ~active_bank;
      if ((rd_en && rd_bad) || wr_bad) addr_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vector_pingpong_mem.sv
// Directed bench for vector_pingpong_mem with a 16-word bank.
// Each step drives inputs, clocks once, and checks outputs just after the edge.
module tb_vector_pingpong_mem;

  localparam int EW = 64;
  localparam int NU = 8;
  localparam int AW = 20;
  localparam int DP = 16;
  localparam int DW = EW * NU;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_en = 1'b0;
  logic [NU-1:0] wr_lane_mask = '0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          rd_en = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          swap = 1'b0;
  logic          clear_start = 1'b0;
  logic          busy;
  logic          finish;
  logic          active_bank;
  logic          addr_err;

  int checks = 0;
  int errors = 0;

  vector_pingpong_mem #(
    .element_width(EW),
    .no_of_units  (NU),
    .address_width(AW),
    .depth        (DP)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_en       (wr_en),
    .wr_lane_mask(wr_lane_mask),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .rd_en       (rd_en),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .swap        (swap),
    .clear_start (clear_start),
    .busy        (busy),
    .finish      (finish),
    .active_bank (active_bank),
    .addr_err    (addr_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [DW-1:0] obs,
                     input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_in();
    wr_en = 1'b0;
    wr_lane_mask = '0;
    rd_en = 1'b0;
    swap = 1'b0;
    clear_start = 1'b0;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [NU-1:0] m,
                    input logic [DW-1:0] d, input logic sw);
    wr_en = 1'b1;
    wr_addr = a;
    wr_lane_mask = m;
    wr_data = d;
    swap = sw;
    step();
    idle_in();
  endtask

  task automatic rd(input logic [AW-1:0] a);
    rd_en = 1'b1;
    rd_addr = a;
    step();
    idle_in();
  endtask

  task automatic do_swap();
    swap = 1'b1;
    step();
    idle_in();
  endtask

  logic [DW-1:0] pat_a, ones, lane0, val5;
  int busy_n, fin_n, fin_at;
  logic all_zero;
  logic bank_before;

  initial begin
    pat_a = {NU{64'hAAAA_AAAA_AAAA_AAAA}};
    ones  = '1;
    lane0 = {{(DW-EW){1'b0}}, {EW{1'b1}}};
    val5  = {NU{64'h0123_4567_89AB_CDEF}};

    // reset state
    #2;
    chk("rst_rd_data", rd_data, '0);
    chk("rst_rd_valid", DW'(rd_valid), '0);
    chk("rst_busy", DW'(busy), '0);
    chk("rst_finish", DW'(finish), '0);
    chk("rst_active", DW'(active_bank), '0);
    chk("rst_addr_err", DW'(addr_err), '0);
    step();
    rst_n = 1'b1;
    step();

    // 1: full write to shadow bank 1, swap, read back
    wr(5, '1, pat_a, 1'b0);
    do_swap();
    chk("t1_active", DW'(active_bank), DW'(1));
    rd(5);
    chk("t1_rd_data", rd_data, pat_a);
    chk("t1_rd_valid", DW'(rd_valid), DW'(1));
    step();
    chk("t1_valid_drop", DW'(rd_valid), '0);
    chk("t1_data_hold", rd_data, pat_a);

    // 2: masked write into bank 0
    wr(3, '1, '0, 1'b0);
    wr(3, 8'b0000_0001, ones, 1'b0);
    do_swap();
    rd(3);
    chk("t2_lane0_only", rd_data, lane0);

    // 5: write and swap on the same edge
    wr(2, '1, val5, 1'b1);
    chk("t5_active", DW'(active_bank), DW'(1));
    rd(2);
    chk("t5_rd_data", rd_data, val5);

    // 4: out-of-range write and read
    chk("t4_err_before", DW'(addr_err), '0);
    wr(DP, 8'b0000_0000, ones, 1'b0);
    chk("t4_zero_mask_no_err", DW'(addr_err), '0);
    wr(DP, '1, ones, 1'b0);
    chk("t4_wr_err", DW'(addr_err), DW'(1));
    rd(DP + 7);
    chk("t4_rd_zero", rd_data, '0);
    chk("t4_rd_valid", DW'(rd_valid), DW'(1));

    // 3: clear shadow bank 0 while bank 1 is active
    wr(0, '1, pat_a, 1'b0);
    bank_before = active_bank;
    clear_start = 1'b1;
    step();
    idle_in();
    busy_n = 0;
    fin_n = 0;
    fin_at = -1;
    for (int i = 0; i < 40; i++) begin
      if (busy) busy_n++;
      if (finish) begin
        fin_n++;
        fin_at = i;
      end
      if (i == 5) begin
        wr_en = 1'b1;
        wr_addr = 0;
        wr_lane_mask = '1;
        wr_data = ones;
        swap = 1'b1;
        clear_start = 1'b1;
      end
      step();
      idle_in();
    end
    chk("t3_busy_cycles", DW'(busy_n), DW'(DP));
    chk("t3_finish_count", DW'(fin_n), DW'(1));
    chk("t3_finish_time", DW'(fin_at), DW'(DP));
    chk("t3_swap_ignored", DW'(active_bank), DW'(bank_before));
    do_swap();
    chk("t3_active_after", DW'(active_bank), DW'(0));
    all_zero = 1'b1;
    for (int a = 0; a < DP; a++) begin
      rd(AW'(a));
      if (rd_data !== '0 || rd_valid !== 1'b1) all_zero = 1'b0;
    end
    chk("t3_all_zero", DW'(all_zero), DW'(1));
    chk("t3_err_sticky", DW'(addr_err), DW'(1));

    // 6: reset in the middle of a clear
    do_swap();
    clear_start = 1'b1;
    step();
    idle_in();
    for (int i = 0; i < 4; i++) step();
    chk("t6_busy_mid", DW'(busy), DW'(1));
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_busy_rst", DW'(busy), '0);
    chk("t6_active_rst", DW'(active_bank), '0);
    chk("t6_err_rst", DW'(addr_err), '0);
    fin_n = 0;
    for (int i = 0; i < 3; i++) begin
      if (finish) fin_n++;
      step();
    end
    rst_n = 1'b1;
    for (int i = 0; i < 25; i++) begin
      if (finish) fin_n++;
      step();
    end
    chk("t6_no_finish", DW'(fin_n), '0);
    chk("t6_busy_idle", DW'(busy), '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
